// File: rtl/xbar_cfg.sv
// Configurable bit crossbar: every output bit picks one input bit through a
// select field. Select fields are streamed in chunk by chunk into a shadow
// register and only copied to the active configuration in a single commit
// cycle, so the routed outputs never observe a partially loaded setup.
module xbar_cfg #(
   parameter int IN_WIDTH  = 15,
   parameter int OUT_WIDTH = 16,
   parameter int SEL_WIDTH = 4,
   parameter int CFG_CHUNK = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [IN_WIDTH-1:0]             io_xbar_in,
   output logic [OUT_WIDTH-1:0]            io_xbar_out,
   input  logic                            io_cfg_start,
   input  logic                            io_cfg_valid,
   output logic                            io_cfg_ready,
   input  logic [CFG_CHUNK-1:0]            io_cfg_data,
   output logic                            io_cfg_busy,
   output logic                            io_cfg_done,
   output logic [OUT_WIDTH*SEL_WIDTH-1:0]  io_active_cfg
);

   localparam int CFG_BITS    = OUT_WIDTH * SEL_WIDTH;
   localparam int NUM_CHUNKS  = (CFG_BITS + CFG_CHUNK - 1) / CFG_CHUNK;
   localparam int SHADOW_BITS = NUM_CHUNKS * CFG_CHUNK;
   localparam int CNT_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int PAD_WIDTH   = 1 << SEL_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t                  state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic [SHADOW_BITS-1:0]  shadow_reg, shadow_next;
   logic [CFG_BITS-1:0]     active_reg;
   logic                    done_reg;
   logic [OUT_WIDTH-1:0]    xbar_out_reg;
   logic [OUT_WIDTH-1:0]    xbar_out_next;
   logic [PAD_WIDTH-1:0]    in_pad;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state, load bookkeeping and handshake outputs
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      shadow_next  = shadow_reg;
      io_cfg_ready = 1'b0;
      io_cfg_busy  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (io_cfg_start) begin
               state_next  = LOAD;
               cnt_next    = '0;
               shadow_next = '0;
            end
         end
         LOAD: begin
            io_cfg_ready = 1'b1;
            io_cfg_busy  = 1'b1;
            if (io_cfg_start) begin
               // Restart drops any beat offered in the same cycle
               cnt_next    = '0;
               shadow_next = '0;
            end else if (io_cfg_valid) begin
               shadow_next[cnt_reg*CFG_CHUNK +: CFG_CHUNK] = io_cfg_data;
               if (cnt_reg == CNT_W'(NUM_CHUNKS - 1)) begin
                  state_next = COMMIT;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         COMMIT: begin
            io_cfg_busy = 1'b1;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Chunk counter and shadow configuration
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg    <= '0;
         shadow_reg <= '0;
      end else begin
         cnt_reg    <= cnt_next;
         shadow_reg <= shadow_next;
      end
   end

   // Active configuration swaps atomically in COMMIT; done flags it one cycle later
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_reg <= '0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= (state_reg == COMMIT);
         if (state_reg == COMMIT) begin
            active_reg <= shadow_reg[CFG_BITS-1:0];
         end
      end
   end

   // Zero-extend the inputs so out-of-range selects read a constant 0
   always_comb begin
      in_pad                 = '0;
      in_pad[IN_WIDTH-1:0]   = io_xbar_in;
   end

   genvar gi;
   generate
      for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_route
         logic [SEL_WIDTH-1:0] sel;
         assign sel               = active_reg[gi*SEL_WIDTH +: SEL_WIDTH];
         assign xbar_out_next[gi] = in_pad[sel];
      end
   endgenerate

   // Registered crossbar outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xbar_out_reg <= '0;
      end else begin
         xbar_out_reg <= xbar_out_next;
      end
   end

   assign io_xbar_out   = xbar_out_reg;
   assign io_cfg_done   = done_reg;
   assign io_active_cfg = active_reg;

endmodule

// File: tb/tb_xbar_cfg.sv
// Self-checking bench for xbar_cfg: directed scenarios plus random traffic,
// all compared each cycle against a transaction-level reference model.
module tb_xbar_cfg;

   localparam int IW = 15;
   localparam int OW = 16;
   localparam int SW = 4;
   localparam int CH = 8;
   localparam int CB = OW * SW;
   localparam int NC = (CB + CH - 1) / CH;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic [IW-1:0] xin   = '0;
   logic [OW-1:0] xout;
   logic          start = 1'b0;
   logic          valid = 1'b0;
   logic          ready;
   logic [CH-1:0] data  = '0;
   logic          busy;
   logic          done;
   logic [CB-1:0] active;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit            m_loading;
   bit            m_commit;
   bit            m_done;
   int            m_count;
   logic [CH-1:0] m_bytes [NC];
   logic [CB-1:0] m_active;
   logic [OW-1:0] m_out;

   always #5 clk = ~clk;

   xbar_cfg #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SEL_WIDTH(SW), .CFG_CHUNK(CH)) dut (
      .clk           (clk),
      .reset         (reset),
      .io_xbar_in    (xin),
      .io_xbar_out   (xout),
      .io_cfg_start  (start),
      .io_cfg_valid  (valid),
      .io_cfg_ready  (ready),
      .io_cfg_data   (data),
      .io_cfg_busy   (busy),
      .io_cfg_done   (done),
      .io_active_cfg (active)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [CB-1:0] model_cfg();
      logic [NC*CH-1:0] acc = '0;
      for (int k = 0; k < NC; k++) acc[k*CH +: CH] = m_bytes[k];
      return acc[CB-1:0];
   endfunction

   function automatic logic [OW-1:0] route(input logic [CB-1:0] cfg, input logic [IW-1:0] inp);
      logic [OW-1:0] r = '0;
      for (int j = 0; j < OW; j++) begin
         int sel = int'(cfg[j*SW +: SW]);
         r[j] = (sel < IW) ? inp[sel] : 1'b0;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_loading = 0; m_commit = 0; m_done = 0; m_count = 0;
      m_active = '0; m_out = '0;
      for (int k = 0; k < NC; k++) m_bytes[k] = '0;
   endtask

   task automatic model_edge();
      logic [OW-1:0] nout;
      nout   = route(m_active, xin);
      m_done = m_commit;
      if (m_commit) begin
         m_active = model_cfg();
         m_commit = 0;
      end else if (!m_loading) begin
         if (start) begin
            m_loading = 1; m_count = 0;
            for (int k = 0; k < NC; k++) m_bytes[k] = '0;
         end
      end else if (start) begin
         m_count = 0;
         for (int k = 0; k < NC; k++) m_bytes[k] = '0;
      end else if (valid) begin
         m_bytes[m_count] = data;
         m_count++;
         if (m_count == NC) begin
            m_loading = 0;
            m_commit  = 1;
         end
      end
      m_out = nout;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".out"},    64'(xout),   64'(m_out));
      check({tag, ".ready"},  64'(ready),  64'(m_loading));
      check({tag, ".busy"},   64'(busy),   64'(m_loading || m_commit));
      check({tag, ".done"},   64'(done),   64'(m_done));
      check({tag, ".active"}, 64'(active), 64'(m_active));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (!reset) model_reset();
      else model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic beat(input logic [CH-1:0] d, input string tag);
      start = 0; valid = 1; data = d;
      step(tag);
      valid = 0;
   endtask

   // Full load with optional idle gaps; counts done pulses and busy drops
   task automatic load_cfg(input logic [CH-1:0] b [NC], input int gap, input string tag,
                           output int dones, output int busy_lows);
      dones = 0; busy_lows = 0;
      start = 1; step(tag); start = 0;
      for (int k = 0; k < NC; k++) begin
         beat(b[k], tag);
         if (done) dones++;
         if (!busy) busy_lows++;
         if (k != NC - 1) begin
            repeat (gap) begin
               step(tag);
               if (done) dones++;
               if (!busy) busy_lows++;
            end
         end
      end
      check({tag, ".commit_busy"}, 64'(busy), 64'd1);
      check({tag, ".commit_nodone"}, 64'(done), 64'd0);
      step(tag);
      if (done) dones++;
      $display("load %s gap=%0d active=%h done=%0d", tag, gap, active, done);
   endtask

   logic [CH-1:0] seq_bytes [NC];
   logic [CH-1:0] ee_bytes  [NC];
   int dn, bl;

   initial begin
      for (int k = 0; k < NC; k++) begin
         seq_bytes[k] = CH'(((2*k+1) << 4) | (2*k));
         ee_bytes[k]  = 8'hEE;
      end
      model_reset();

      // Asynchronous reset
      #2 reset = 0;
      #1 compare_all("reset");
      step("reset_hold");
      reset = 1;

      // Default config routes input 0 everywhere
      xin = 15'h0001; step("route0_a");
      check("route0_ones", 64'(xout), 64'hFFFF);
      xin = 15'h0000; step("route0_b");
      check("route0_zero", 64'(xout), 64'h0000);

      // Sequential selects, no gaps
      xin = 15'h5555;
      load_cfg(seq_bytes, 0, "seq", dn, bl);
      check("seq.done", 64'(done), 64'd1);
      check("seq.active", 64'(active), 64'hFEDCBA9876543210);
      step("seq_post");
      check("seq.out", 64'(xout), 64'h5555);

      // Same config with 3-cycle valid gaps
      load_cfg(seq_bytes, 3, "gap", dn, bl);
      step("gap_post");
      if (done) dn++;
      check("gap.done_count", 64'(dn), 64'd1);
      check("gap.busy_lows", 64'(bl), 64'd0);
      check("gap.active", 64'(active), 64'hFEDCBA9876543210);

      // Restart after 4 beats, then all-14 config; input toggles every cycle
      start = 1; step("rst_load"); start = 0;
      for (int k = 0; k < 4; k++) begin
         xin = IW'($urandom);
         beat(CH'($urandom), "partial");
      end
      start = 1; valid = 1; data = 8'h33; step("restart"); start = 0; valid = 0;
      for (int k = 0; k < NC; k++) begin
         xin = IW'($urandom);
         beat(ee_bytes[k], "ee");
      end
      xin = IW'($urandom); step("ee_commit");
      check("ee.done", 64'(done), 64'd1);
      check("ee.active", 64'(active), 64'hEEEEEEEEEEEEEEEE);
      xin = 15'h4000; step("ee_a"); step("ee_b");
      check("ee.out", 64'(xout), 64'hFFFF);

      // Reset during beat 5 over the all-14 config
      start = 1; step("mid_load"); start = 0;
      for (int k = 0; k < 4; k++) beat(CH'($urandom), "mid_load");
      valid = 1; data = 8'h12;
      #2 reset = 0;
      #1 model_reset();
      compare_all("midrst");
      check("midrst.active", 64'(active), 64'd0);
      step("midrst_hold");
      reset = 1;
      repeat (3) step("post_rst_idle");
      check("post_rst.ready", 64'(ready), 64'd0);
      valid = 0;

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 39) == 0);
         valid = $urandom_range(0, 1);
         data  = CH'($urandom);
         xin   = IW'($urandom);
         step("rand");
         if (done) $display("rand commit cycle=%0d active=%h", i, active);
      end
      start = 0; valid = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/xbar_cfg.md
Name: xbar_cfg

Overview:
- Parametrised successor to the fixed 15-in/16-out LUT-tile crossbar.
- Each output bit selects one input bit through a per-output select field.
- Select fields are loaded serially in chunks into a shadow register, then committed atomically to the active config. Outputs never see a half-written configuration.
- Outputs are registered. The block sits between the tile input routing and the LUT input pins.

Parameters:
- IN_WIDTH, 15, number of crossbar input bits.
- OUT_WIDTH, 16, number of crossbar output bits.
- SEL_WIDTH, 4, select field width per output. Must satisfy 2^SEL_WIDTH >= IN_WIDTH.
- CFG_CHUNK, 8, config bits accepted per load beat.
- Derived: CFG_BITS = OUT_WIDTH*SEL_WIDTH (64); NUM_CHUNKS = ceil(CFG_BITS/CFG_CHUNK) (8).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- io_xbar_in  input  IN_WIDTH  crossbar data inputs.
- io_xbar_out  output  OUT_WIDTH  registered crossbar outputs.
- io_cfg_start  input  1  begin a new config load.
- io_cfg_valid  input  1  io_cfg_data carries a chunk.
- io_cfg_ready  output  1  block accepts a chunk this cycle.
- io_cfg_data  input  CFG_CHUNK  config chunk, LSB-first.
- io_cfg_busy  output  1  high in LOAD or COMMIT.
- io_cfg_done  output  1  one-cycle pulse when the new config becomes active.
- io_active_cfg  output  CFG_BITS  readback of the active config.

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE; chunk counter is 0.
  - Shadow and active configs are 0, so every output selects input 0.
  - io_xbar_out=0, io_cfg_ready=0, io_cfg_busy=0, io_cfg_done=0.
- Datapath:
  - Output j uses sel_j = active[j*SEL_WIDTH +: SEL_WIDTH].
  - Every cycle: io_xbar_out[j] <= (sel_j < IN_WIDTH) ? io_xbar_in[sel_j] : 0.
  - Out-of-range selects drive 0 and never produce X.
  - Latency is 1 cycle from io_xbar_in to io_xbar_out.
- FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - io_cfg_ready=0; io_cfg_valid is ignored.
  - io_cfg_start=1 -> LOAD, with counter=0 and shadow cleared to 0.
- LOAD:
  - io_cfg_ready=1.
  - A beat transfers when valid&&ready. Chunk k is written to shadow[k*CFG_CHUNK +: CFG_CHUNK]; counter increments.
  - Bits beyond CFG_BITS in the last chunk are discarded.
  - The beat with counter==NUM_CHUNKS-1 -> COMMIT.
  - valid=0 stalls indefinitely; there is no timeout.
- COMMIT (exactly one cycle):
  - io_cfg_ready=0; active <= shadow at the end of the cycle.
  - io_cfg_done=1 in the cycle after COMMIT, coincident with io_active_cfg showing the new value. State returns to IDLE.
  - io_xbar_out reflects the new config from the edge after io_cfg_done rises (one register stage after the active update).
- io_cfg_start in LOAD restarts the load: counter=0, shadow cleared, any valid beat in that cycle is dropped. Active config is untouched.
- io_cfg_start in COMMIT is ignored, and the commit completes. io_cfg_start in the done cycle (IDLE) starts a new load normally.
- io_cfg_start and io_cfg_valid in the same IDLE cycle: start is taken, data is not captured (ready was 0).
- Reset mid-LOAD or mid-COMMIT: the full reset state applies, and the active config reverts to 0, not to the previous config.
- The active config changes only in COMMIT. The datapath runs undisturbed during LOAD.

Test Plan:
- Reset then io_xbar_in=15'h0001 -> after 1 clk all io_xbar_out=16'hFFFF (all select input 0); io_xbar_in=0 -> 16'h0000.
- Load chunks 8'h10,32,54,76,98,BA,DC,FE (select j=j, output 15 select=15) with io_xbar_in=15'h5555 -> done pulses 1 cycle after the 8th beat; io_xbar_out=16'h5555 (bit 15 = 0, out of range); io_active_cfg=64'hFEDCBA9876543210.
- Insert valid=0 gaps of 3 cycles between every beat -> identical final config; busy stays high throughout; done pulses once.
- After 4 beats assert io_cfg_start, then 8 beats of 8'hEE -> every select=14; io_xbar_in=15'h4000 gives io_xbar_out=16'hFFFF; the first 4 beats leave no trace.
- Pull reset low during beat 5 of a load over an active all-14 config -> io_active_cfg=0, io_xbar_out=0; io_cfg_ready=0 until the next io_cfg_start.
- Toggle io_xbar_in every cycle during LOAD -> io_xbar_out keeps following the old config with 1-cycle latency until the edge after done.
